// File: rtl/uart_frame_guard.sv
// Frame header check and link watchdog behind the UART receiver: publishes validated
// payloads and raises link_ok only after a run of good frames, dropping it on silence.
module uart_frame_guard #(
  parameter int          BUFFER_SIZE  = 80,
  parameter logic [31:0] MSGID        = 32'h74697277,
  parameter logic [31:0] TIMEOUT      = 32'd4800000,
  parameter int          REARM_FRAMES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BUFFER_SIZE-1:0]  frame_data,
  input  logic                    frame_strobe,
  output logic [BUFFER_SIZE-33:0] payload,
  output logic                    payload_valid,
  output logic                    link_ok,
  output logic                    timeout,
  output logic [7:0]              bad_frames,
  output logic [15:0]             good_frames
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    FAULT = 2'b10
  } state_t;

  localparam logic [7:0] REARM_U8 = 8'(REARM_FRAMES);

  state_t      state;
  logic [31:0] wd;
  logic [7:0]  rc;
  logic        isGood;
  logic        isBad;
  logic        expiry;
  logic        rearmDone;

  function automatic logic [7:0] satInc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign isGood    = frame_strobe && (frame_data[BUFFER_SIZE-1 -: 32] == MSGID);
  assign isBad     = frame_strobe && !isGood;
  // A good frame arriving while the watchdog is at its limit still wins.
  assign expiry    = (wd == TIMEOUT) && !isGood;
  assign rearmDone = (rc + 8'd1) == REARM_U8;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      wd            <= '0;
      rc            <= '0;
      payload       <= '0;
      payload_valid <= 1'b0;
      link_ok       <= 1'b0;
      timeout       <= 1'b0;
      bad_frames    <= '0;
      good_frames   <= '0;
    end else begin
      payload_valid <= isGood;
      if (isGood) begin
        payload     <= frame_data[BUFFER_SIZE-33:0];
        good_frames <= good_frames + 16'd1;
        wd          <= '0;
      end else if (wd != TIMEOUT) begin
        wd <= wd + 32'd1;
      end
      if (isBad)
        bad_frames <= satInc8(bad_frames);

      case (state)
        IDLE, FAULT: begin
          if (isBad || expiry) begin
            rc <= '0;
          end else if (isGood) begin
            if (rearmDone) begin
              state   <= RUN;
              rc      <= '0;
              link_ok <= 1'b1;
              timeout <= 1'b0;
            end else begin
              rc <= rc + 8'd1;
            end
          end
        end
        RUN: begin
          rc <= '0;
          if (expiry) begin
            state   <= FAULT;
            link_ok <= 1'b0;
            timeout <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          rc      <= '0;
          link_ok <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_frame_guard.md
# uart_frame_guard

Frame validation and link watchdog stage directly downstream of the UART interface. Takes each complete received frame plus a one-cycle arrival strobe, checks the 32-bit MSGID header, and publishes only validated payloads. Tracks link health with a watchdog and a re-arm state machine; `link_ok` gates the output enables of downstream plugins, giving a safe stop on link loss.

## Interface

- `BUFFER_SIZE`, 80, frame width in bits, multiple of 8, ≥ 40; MSGID occupies bits [BUFFER_SIZE-1:BUFFER_SIZE-32]
- `MSGID`, 32'h74697277, required header word
- `TIMEOUT`, 32'd4800000, cycles without a good frame before a fault; ≥ 2
- `REARM_FRAMES`, 4, consecutive good frames needed to enter RUN; 1..255

- `clk`  in  1  system clock; one clock domain
- `rst`  in  1  synchronous, active-high reset
- `frame_data`  in  BUFFER_SIZE  received frame; stable while `frame_strobe` is high
- `frame_strobe`  in  1  one-cycle pulse per complete frame
- `payload`  out  BUFFER_SIZE-32  payload bits of the last good frame; reset 0
- `payload_valid`  out  1  one-cycle pulse per good frame; reset 0
- `link_ok`  out  1  high only in RUN; reset 0
- `timeout`  out  1  sticky fault flag; reset 0
- `bad_frames`  out  8  header-mismatch count, saturates at 255; reset 0
- `good_frames`  out  16  good-frame count, wraps; reset 0

## Operation

- Good frame: strobe high and header == MSGID. Bad frame: strobe high and header != MSGID.
- Good frame, any state: `payload` <= frame_data[BUFFER_SIZE-33:0]; pulse `payload_valid`; `good_frames`+1; watchdog cleared.
- Bad frame, any state: `bad_frames`+1 (saturating); payload, watchdog and outputs untouched; re-arm counter cleared.
- Watchdog `wd`, 32 bits: cleared by a good frame; otherwise increments, saturating at TIMEOUT. Expiry = `wd` reaching TIMEOUT.
- Re-arm counter `rc`, 8 bits: +1 per good frame in IDLE/FAULT. Cleared by a bad frame, by watchdog expiry, and on entering RUN.
- States:
  - IDLE (reset): link_ok=0, timeout=0. When the good frame that makes `rc` reach REARM_FRAMES arrives -> RUN.
  - RUN: link_ok=1. On watchdog expiry -> FAULT, setting timeout=1 and link_ok=0. A bad frame does not leave RUN.
  - FAULT: link_ok=0, timeout=1. Uses the same re-arm rule as IDLE -> RUN, and clears timeout.
- Encoding 2'b00 IDLE, 2'b01 RUN, 2'b10 FAULT; 2'b11 -> IDLE on the next cycle.
- Payload keeps updating in IDLE/FAULT; consumers qualify it with `link_ok`.

## Timing

- All outputs are registered. Strobe sampled at edge N gives updated payload, `payload_valid`, counters, state, link_ok and timeout visible after edge N+1. Latency is 1 cycle.
- Strobes on consecutive cycles are each processed; no back-pressure.
- Expiry: last good frame sampled at edge N with no good frame after it -> FAULT visible after edge N+TIMEOUT+1.
- Good frame on the same edge that `wd` would reach TIMEOUT: the good frame wins. `wd` clears and there is no fault.
- REARM_FRAMES=1: a single good frame moves IDLE/FAULT -> RUN.
- `rst` high at any edge, including mid-frame or in FAULT: every output and internal register returns to its reset value on that edge. A strobe coinciding with `rst` is ignored.

## Test plan

- Bench parameters TIMEOUT=100, REARM_FRAMES=4, default MSGID. After reset, 4 good frames spaced 10 cycles apart -> link_ok rises 1 cycle after the 4th strobe; good_frames=4; payload equals the 4th frame's low 48 bits.
- IDLE, 3 good frames, 1 bad frame, then 4 good frames -> bad_frames=1; link_ok rises only after the 7th good frame overall.
- RUN, then strobes stop -> link_ok falls and timeout rises exactly 101 cycles after the last good strobe. Then 4 good frames -> timeout clears and link_ok=1.
- RUN, good frame arrives exactly 100 cycles after the previous one -> no fault; link_ok stays 1.
- 300 bad frames -> bad_frames=255 (saturated); payload_valid never pulses; payload unchanged.
- Assert `rst` in FAULT on the same cycle as a good strobe -> all outputs 0 next cycle; state IDLE; good_frames=0.
